data_deframer: RTL and testbench
================================

# data_deframer

AXI-Stream receiver for TLAST-framed pixel bursts of 2**FRAME_LEN_LOG2 beats, as produced by the pixel-side framer. It locks to frame boundaries, checks every frame's length, and strips the 32-bit beat to 24-bit pixel data. It forwards pixels downstream with a start-of-frame flag, keeps good, short and long frame counters, and resynchronises after a length error. It sits at the consumer end of the stream, after DMA loopback or on the sink side of the framer in test designs.

## Interface
- C_S00_AXIS_TDATA_WIDTH, 32, input beat width; pixel is bits [23:0].
- FRAME_LEN_LOG2, 16, log2 of the expected frame length in beats; benches use 4.
- pixel_clk  in  1  single clock for all logic.
- pixel_rstn  in  1  reset, asynchronous and active-low.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tready  out  1  input ready.
- s00_axis_tlast  in  1  input end of frame.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  beat; [31:24] ignored.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  accepted and ignored.
- m00_axis_tvalid  out  1  pixel valid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  24  pixel.
- m00_axis_tuser  out  1  first pixel of a frame.
- m00_axis_tlast  out  1  last pixel of a frame (natural or forced).
- err_clear  in  1  synchronous clear of the error counters.
- locked  out  1  high while in PASS.
- frame_count  out  16  good frames forwarded; wraps mod 2**16.
- short_count  out  16  frames ended by early TLAST; saturates at 0xFFFF.
- long_count  out  16  frames with no TLAST at beat LEN-1; saturates at 0xFFFF.

## Operation
- A beat is accepted when s00_axis_tvalid and s00_axis_tready are both high.
- beat_cnt is FRAME_LEN_LOG2 bits wide and indexes the current frame. LEN = 2**FRAME_LEN_LOG2.
- The FSM has three states: HUNT, PASS and DROP. Reset enters HUNT.
- HUNT:
  - s00_axis_tready=1; accepted beats are discarded.
  - An accepted beat with tlast moves the FSM to PASS with beat_cnt=0.
- PASS:
  - s00_axis_tready equals skid-buffer ready.
  - Each accepted beat is pushed with tdata[23:0], tuser=(beat_cnt==0) and the tlast rule below; beat_cnt then increments.
  - tlast with beat_cnt==LEN-1: good frame. Push with tlast=1, frame_count++, beat_cnt=0.
  - tlast with beat_cnt<LEN-1: short frame. Push with tlast=1, short_count++, beat_cnt=0, stay in PASS.
  - No tlast with beat_cnt==LEN-1: long frame. Push with tlast=1 (forced), long_count++, go to DROP.
- DROP:
  - s00_axis_tready=1; accepted beats are discarded.
  - An accepted tlast returns the FSM to PASS with beat_cnt=0.
- If err_clear and a counter increment occur in the same cycle, err_clear wins: short_count and long_count become 0. frame_count is unaffected by err_clear.
- A 1-beat frame with LEN=1 is legal and counts as good.

## Timing
- Reset (asynchronous, pixel_rstn=0):
  - state=HUNT, beat_cnt=0, skid buffer empty.
  - All m00_* outputs are 0; s00_axis_tready=0 while reset is asserted.
  - locked=0 and all counters are 0.
  - Reset mid-frame discards buffered data.
  - After reset releases, s00_axis_tready rises on the first clock edge.
- Latency: a beat accepted on edge N appears on m00 at edge N+1, provided the buffer is empty.
- The skid buffer holds 2 entries.
  - s00_axis_tready in PASS is registered and equals "buffer not full".
  - Zero bubbles at full throughput; no combinational path from m00_axis_tready to s00_axis_tready.
- m00 data is stable while m00_axis_tvalid=1 and m00_axis_tready=0 (AXIS rule). The buffer drains in HUNT and DROP as well.
- Counters and locked update on the edge after the deciding beat is accepted.
- The counter width rule: beat_cnt compares with LEN-1 at exactly FRAME_LEN_LOG2 bits; no wrap into bit FRAME_LEN_LOG2.

## Structure
- Package data_deframer_pkg:
  - state enum {HUNT, PASS, DROP}.
  - PIXEL_W=24.
  - Counter width 16 and the saturate-increment function.
- Sub-module axis_skid_buffer: 2-entry, parameter DATA_W.
  - Carries {tuser, tlast, tdata} = 26 bits.
  - Registered in_ready; valid/ready on both sides.
- The top level holds the FSM, beat_cnt and the counters.

## Test plan
All scenarios use FRAME_LEN_LOG2=4 (LEN=16).
- Reset, then 3 back-to-back 16-beat frames with tlast on beat 15:
  - Frame 1 is discarded in HUNT.
  - Frames 2 and 3 are output with tuser on beat 0 and tlast on beat 15.
  - frame_count=2, locked=1.
- Lock, then a frame with tlast on beat 9:
  - 10 pixels out, tlast on the 10th.
  - short_count=1.
  - The next 16-beat frame is output intact.
- Lock, then a frame of 20 beats with tlast on beat 19:
  - 16 pixels out, tlast forced on the 16th.
  - long_count=1; beats 17-20 are dropped and locked=0 during them.
  - The next frame is output intact.
- Random 50% m00_axis_tready against a continuous-valid source with incrementing data:
  - Output sequence is identical, with no loss or duplication.
  - tuser/tlast are aligned, and data is held while stalled.
- Assert pixel_rstn low at beat 7 of a locked frame:
  - All outputs go to 0 immediately.
  - After release the block is back in HUNT; the remainder of the frame is discarded and the next frame is output only after a tlast.
- err_clear pulses on the same cycle as a short-frame tlast with short_count=3:
  - short_count=0 next cycle.
  - frame_count is unchanged.

Source files
------------

// File: rtl/data_deframer_pkg.sv
// Shared types and helpers for the TLAST-framed pixel deframer.
package data_deframer_pkg;

  typedef enum logic [1:0] {HUNT, PASS, DROP} state_e;

  localparam int PIXEL_W = 24;
  localparam int CNT_W   = 16;
  localparam int BEAT_W  = PIXEL_W + 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Pixel plus sideband as carried through the skid buffer: {tuser, tlast, tdata}.
  typedef struct packed {
    logic               tuser;
    logic               tlast;
    logic [PIXEL_W-1:0] tdata;
  } beat_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer; in_ready is a flop, so downstream ready never
// reaches the upstream ready combinationally.
module axis_skid_buffer #(
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_next;
  logic              push;
  logic              pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    count_next = count + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two storage words are reset so out_data reads 0 during reset.
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_next;
      in_ready <= (count_next != 2'd2);
    end
  end

endmodule

// File: rtl/data_deframer.sv
// Locks to TLAST frame boundaries, checks frame length, strips beats to 24-bit
// pixels with SOF/EOF sideband, and counts good, short and long frames.
module data_deframer
  import data_deframer_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN_LOG2         = 16
) (
  input  logic                                pixel_clk,
  input  logic                                pixel_rstn,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [PIXEL_W-1:0]                  m00_axis_tdata,
  output logic                                m00_axis_tuser,
  output logic                                m00_axis_tlast,
  input  logic                                err_clear,
  output logic                                locked,
  output logic [CNT_W-1:0]                    frame_count,
  output logic [CNT_W-1:0]                    short_count,
  output logic [CNT_W-1:0]                    long_count
);

  localparam int CNT_BITS = (FRAME_LEN_LOG2 > 0) ? FRAME_LEN_LOG2 : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT =
    CNT_BITS'((64'd1 << FRAME_LEN_LOG2) - 64'd1);

  state_e              state;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                run_q;
  logic                skid_ready;
  logic                accept;
  logic                at_last;
  logic                push_valid;
  beat_t               push_beat;
  beat_t               pop_beat;
  logic                unused_in;

  assign unused_in = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:PIXEL_W]};

  // run_q keeps tready low in reset and raises it on the first edge after release.
  assign s00_axis_tready = run_q & ((state != PASS) | skid_ready);
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign at_last         = (beat_cnt == LAST_BEAT);
  assign push_valid      = (state == PASS) & s00_axis_tvalid & run_q;

  assign push_beat = '{tuser: (beat_cnt == '0),
                       tlast: s00_axis_tlast | at_last,
                       tdata: s00_axis_tdata[PIXEL_W-1:0]};

  axis_skid_buffer #(.DATA_W(BEAT_W)) u_skid (
    .clk       (pixel_clk),
    .rst_n     (pixel_rstn),
    .in_valid  (push_valid),
    .in_ready  (skid_ready),
    .in_data   (push_beat),
    .out_valid (m00_axis_tvalid),
    .out_ready (m00_axis_tready),
    .out_data  (pop_beat)
  );

  assign m00_axis_tdata = pop_beat.tdata;
  assign m00_axis_tuser = pop_beat.tuser;
  assign m00_axis_tlast = pop_beat.tlast;

  always_ff @(posedge pixel_clk or negedge pixel_rstn) begin
    if (!pixel_rstn) begin
      state       <= HUNT;
      beat_cnt    <= '0;
      run_q       <= 1'b0;
      locked      <= 1'b0;
      frame_count <= '0;
      short_count <= '0;
      long_count  <= '0;
    end else begin
      run_q <= 1'b1;
      case (state)
        HUNT, DROP: begin
          if (accept && s00_axis_tlast) begin
            state    <= PASS;
            locked   <= 1'b1;
            beat_cnt <= '0;
          end
        end
        PASS: begin
          if (accept) begin
            if (s00_axis_tlast) begin
              beat_cnt <= '0;
              if (at_last) frame_count <= frame_count + cnt_t'(1);
              else         short_count <= sat_inc(short_count);
            end else if (at_last) begin
              beat_cnt   <= '0;
              long_count <= sat_inc(long_count);
              state      <= DROP;
              locked     <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CNT_BITS'(1);
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
      // NOTE: non-blocking assignments; the later clear overrides any increment above.
      if (err_clear) begin
        short_count <= '0;
        long_count  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_deframer.sv
// Directed bench for data_deframer: frame-level reference model, per-cycle output compare.
module tb_data_deframer;

  localparam int LOG2 = 4;
  localparam int LEN  = 16;

  logic        pixel_clk = 1'b0;
  logic        pixel_rstn = 1'b0;
  logic        s00_axis_tvalid = 1'b0;
  logic        s00_axis_tready;
  logic        s00_axis_tlast = 1'b0;
  logic [31:0] s00_axis_tdata = '0;
  logic [3:0]  s00_axis_tstrb = '0;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready = 1'b0;
  logic [23:0] m00_axis_tdata;
  logic        m00_axis_tuser;
  logic        m00_axis_tlast;
  logic        err_clear = 1'b0;
  logic        locked;
  logic [15:0] frame_count;
  logic [15:0] short_count;
  logic [15:0] long_count;

  data_deframer #(.C_S00_AXIS_TDATA_WIDTH(32), .FRAME_LEN_LOG2(LOG2)) dut (
    .pixel_clk       (pixel_clk),
    .pixel_rstn      (pixel_rstn),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tlast  (s00_axis_tlast),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tstrb  (s00_axis_tstrb),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tuser  (m00_axis_tuser),
    .m00_axis_tlast  (m00_axis_tlast),
    .err_clear       (err_clear),
    .locked          (locked),
    .frame_count     (frame_count),
    .short_count     (short_count),
    .long_count      (long_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: expected pixel stream {tuser, tlast, data} and counters.
  logic [25:0] exp_q[$];
  bit          m_locked = 1'b0;
  int          m_frames = 0;
  int          m_short  = 0;
  int          m_long   = 0;
  int          next_data = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare; a handshake seen here completes on the following rising edge.
  logic [25:0] cur_item;
  logic [25:0] prev_item;
  logic [25:0] exp_item;
  bit          prev_stall = 1'b0;

  always @(negedge pixel_clk) begin
    cur_item = {m00_axis_tuser, m00_axis_tlast, m00_axis_tdata};
    if (!pixel_rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stalled valid held", {31'd0, m00_axis_tvalid}, 32'd1);
        check("stalled beat held", {6'd0, cur_item}, {6'd0, prev_item});
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected pixel: got 0x%0h, expected none at %0t", cur_item, $time);
        end else begin
          exp_item = exp_q.pop_front();
          check("pixel {tuser,tlast,data}", {6'd0, cur_item}, {6'd0, exp_item});
        end
      end
      prev_stall = m00_axis_tvalid && !m00_axis_tready;
      prev_item  = cur_item;
    end
  end

  initial begin
    forever begin
      @(posedge pixel_clk);
      #1;
      m00_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Frame-level rules: hunting discards until a tlast; locked frames are cut at LEN.
  task automatic model_frame(input int n, input int base, input bit clr);
    int k;
    if (!m_locked) begin
      m_locked = 1'b1;
    end else begin
      k = (n < LEN) ? n : LEN;
      for (int i = 0; i < k; i++)
        exp_q.push_back({1'(i == 0), 1'(i == k - 1), 24'(base + i)});
      if (n == LEN)     m_frames++;
      else if (n < LEN) m_short++;
      else              m_long++;
    end
    if (clr) begin
      m_short = 0;
      m_long  = 0;
    end
  endtask

  task automatic send_beat(input logic [23:0] px, input logic last, input logic clr);
    int waited = 0;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = {8'hA5 ^ px[7:0], px};
    s00_axis_tlast  = last;
    s00_axis_tstrb  = 4'($urandom);
    err_clear       = clr;
    forever begin
      @(negedge pixel_clk);
      if (s00_axis_tready) break;
      waited++;
      if (waited > 1000) begin
        check("beat accept timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge pixel_clk);
    #1;
    err_clear      = 1'b0;
    s00_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit clr, input bit keep_valid);
    int base = next_data;
    next_data += n;
    model_frame(n, base, clr);
    for (int i = 0; i < n; i++) begin
      if (n > LEN && i >= LEN) check("locked low while dropping", {31'd0, locked}, 32'd0);
      send_beat(24'(base + i), i == n - 1, clr && (i == n - 1));
    end
    if (!keep_valid) s00_axis_tvalid = 1'b0;
    check("locked after frame", {31'd0, locked}, {31'd0, m_locked});
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge pixel_clk);
    repeat (3) @(posedge pixel_clk);
    #1;
    check("pixels left undelivered", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counters();
    check("frame_count", {16'd0, frame_count}, {16'd0, 16'(m_frames)});
    check("short_count", {16'd0, short_count}, {16'd0, 16'(m_short)});
    check("long_count",  {16'd0, long_count},  {16'd0, 16'(m_long)});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " m00_axis_tvalid"}, {31'd0, m00_axis_tvalid}, 32'd0);
    check({tag, " m00_axis_tdata"},  {8'd0, m00_axis_tdata},   32'd0);
    check({tag, " m00_axis_tuser"},  {31'd0, m00_axis_tuser},  32'd0);
    check({tag, " m00_axis_tlast"},  {31'd0, m00_axis_tlast},  32'd0);
    check({tag, " s00_axis_tready"}, {31'd0, s00_axis_tready}, 32'd0);
    check({tag, " locked"},          {31'd0, locked},          32'd0);
    check({tag, " frame_count"},     {16'd0, frame_count},     32'd0);
    check({tag, " short_count"},     {16'd0, short_count},     32'd0);
    check({tag, " long_count"},      {16'd0, long_count},      32'd0);
  endtask

  initial begin
    int base;

    // Reset values and tready rising on the first edge after release.
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check_all_zero("reset");
    #2;
    pixel_rstn = 1'b1;
    #1;
    check("tready before first edge", {31'd0, s00_axis_tready}, 32'd0);
    @(posedge pixel_clk);
    #1;
    check("tready after first edge", {31'd0, s00_axis_tready}, 32'd1);

    // Three back-to-back frames: first is hunted, next two pass.
    send_frame(LEN, 1'b0, 1'b1);
    send_frame(LEN, 1'b0, 1'b1);
    send_frame(LEN, 1'b0, 1'b0);
    drain();
    check_counters();
    check("frame_count after lock", {16'd0, frame_count}, 32'd2);
    check("locked after lock", {31'd0, locked}, 32'd1);

    // Short frame (tlast on beat 9), then an intact frame.
    send_frame(10, 1'b0, 1'b0);
    send_frame(LEN, 1'b0, 1'b0);
    drain();
    check_counters();
    check("short_count after short", {16'd0, short_count}, 32'd1);

    // Long frame of 20 beats, then an intact frame.
    send_frame(20, 1'b0, 1'b0);
    send_frame(LEN, 1'b0, 1'b0);
    drain();
    check_counters();
    check("long_count after long", {16'd0, long_count}, 32'd1);

    // Continuous-valid source against random downstream ready.
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) send_frame(LEN, 1'b0, f < 5);
    drain();
    rand_ready = 1'b0;
    @(posedge pixel_clk);
    #1;
    check_counters();
    check("frame_count after random ready", {16'd0, frame_count}, 32'd10);

    // Reset asserted at beat 7 of a locked frame.
    base = next_data;
    next_data += LEN;
    model_frame(LEN, base, 1'b0);
    for (int i = 0; i < 7; i++) send_beat(24'(base + i), 1'b0, 1'b0);
    pixel_rstn      = 1'b0;
    s00_axis_tvalid = 1'b0;
    exp_q.delete();
    m_locked = 1'b0;
    m_frames = 0;
    m_short  = 0;
    m_long   = 0;
    #1;
    check_all_zero("mid-frame reset");
    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rstn = 1'b1;
    @(posedge pixel_clk);
    #1;
    // Remainder of the interrupted frame is hunted; its tlast relocks.
    check("locked before remainder", {31'd0, locked}, 32'd0);
    model_frame(LEN - 7, base + 7, 1'b0);
    for (int i = 7; i < LEN; i++) send_beat(24'(base + i), i == LEN - 1, 1'b0);
    s00_axis_tvalid = 1'b0;
    check("locked after remainder", {31'd0, locked}, 32'd1);
    send_frame(LEN, 1'b0, 1'b0);
    drain();
    check_counters();
    check("frame_count after reset", {16'd0, frame_count}, 32'd1);

    // err_clear coinciding with a short-frame tlast while short_count is 3.
    send_frame(10, 1'b0, 1'b0);
    send_frame(5,  1'b0, 1'b0);
    send_frame(1,  1'b0, 1'b0);
    drain();
    check("short_count before clear", {16'd0, short_count}, 32'd3);
    send_frame(7, 1'b1, 1'b0);
    check("short_count cleared", {16'd0, short_count}, 32'd0);
    check("frame_count kept on clear", {16'd0, frame_count}, 32'd1);
    drain();
    check_counters();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
